// File: rtl/gzip_axis_packer_if.sv
// Stream bundle between the gzip output FIFO (registered read port) and the
// wide AXIS master side of the packer.
//   fifo_empty/fifo_rden/fifo_data/fifo_last : narrow source FIFO read port
//   m_tdata/m_tkeep/m_tvalid/m_tready/m_tlast : packed AXIS output
// master: the packer; slave: the surrounding FIFO and sink.
interface gzip_axis_packer_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned RATIO = 2
);
    localparam int unsigned OUT_W  = IN_W * RATIO;
    localparam int unsigned KEEP_W = OUT_W / 8;

    logic              fifo_empty;
    logic              fifo_rden;
    logic [IN_W-1:0]   fifo_data;
    logic              fifo_last;
    logic [OUT_W-1:0]  m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        input  fifo_empty, fifo_data, fifo_last, m_tready,
        output fifo_rden, m_tdata, m_tkeep, m_tvalid, m_tlast
    );

    modport slave (
        output fifo_empty, fifo_data, fifo_last, m_tready,
        input  fifo_rden, m_tdata, m_tkeep, m_tvalid, m_tlast
    );
endinterface

// File: rtl/gzip_axis_packer.sv
// Packs RATIO narrow words from a fixed-latency registered-read FIFO into one
// wide AXIS beat with per-byte tkeep on a short final beat. Reads are
// credit-limited against a skid buffer so returning data is always accepted.
// Ports:
//   clk, rst_n   : core clock, asynchronous active-low reset
//   bus (master) : FIFO read port and AXIS output (see gzip_axis_packer_if)
//   beat_count   : beats accepted since reset
//   frame_count  : tlast beats accepted since reset
// Optional: define GZIP_PACKER_STATS_EN to build the beat/frame counters;
// otherwise both count outputs are tied to zero.
module gzip_axis_packer #(
    parameter int unsigned IN_W         = 32,
    parameter int unsigned RATIO        = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BUF_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gzip_axis_packer_if.master bus,
    output logic [31:0]        beat_count,
    output logic [15:0]        frame_count
);
    localparam int unsigned OUT_W  = IN_W * RATIO;
    localparam int unsigned KEEP_W = OUT_W / 8;
    localparam int unsigned IN_B   = IN_W / 8;
    localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W  = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W  = OCC_W + 1;
    localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef struct packed {
        logic            last;
        logic [IN_W-1:0] data;
    } word_t;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    logic                    armed;
    logic [READ_LATENCY-1:0] rd_vld;
    logic [SUM_W-1:0]        inflight;
    logic [OCC_W-1:0]        occ;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    word_t                   buf_mem [BUF_DEPTH];
    word_t                   head;
    logic                    push, pop, start;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [OUT_W-1:0]        asm_data, asm_data_n;
    logic [KEEP_W-1:0]       asm_keep, asm_keep_n;
    logic                    asm_last, asm_last_n;
    logic [OUT_W-1:0]        out_data, out_data_n;
    logic [KEEP_W-1:0]       out_keep, out_keep_n;
    logic                    out_last, out_last_n;
    logic                    out_valid, out_valid_n;

    // Reads in flight = ones in the read-valid pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight = inflight + SUM_W'(rd_vld[i]);
        end
    end

    // armed holds reads off while reset is asserted and for the first edge after.
    assign bus.fifo_rden = armed && !bus.fifo_empty &&
                           ((inflight + SUM_W'(occ)) < SUM_W'(BUF_DEPTH));
    assign push = rd_vld[READ_LATENCY-1];
    assign head = buf_mem[rd_ptr];

    // Skid buffer storage; occupancy is tracked by the pointer/occ registers.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= '{last: bus.fifo_last, data: bus.fifo_data};
        end
    end

    // Byte mask covering slots 0..last_slot.
    function automatic logic [KEEP_W-1:0] keep_for(input logic [IDX_W-1:0] last_slot);
        logic [KEEP_W-1:0] k;
        k = '0;
        for (int s = 0; s < int'(RATIO); s++) begin
            if (IDX_W'(s) <= last_slot) begin
                k[s*IN_B +: IN_B] = '1;
            end
        end
        return k;
    endfunction

    // Pack FSM next state and datapath; HOLD restarts a beat in the cycle it
    // hands off so a new beat can begin every RATIO cycles.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        asm_data_n  = asm_data;
        asm_keep_n  = asm_keep;
        asm_last_n  = asm_last;
        out_data_n  = out_data;
        out_keep_n  = out_keep;
        out_last_n  = out_last;
        out_valid_n = out_valid && !bus.m_tready;
        pop         = 1'b0;
        start       = 1'b0;

        case (state)
            IDLE: begin
                idx_n      = '0;
                asm_data_n = '0;
                start      = (occ != '0);
            end
            FILL: begin
                if (occ != '0) begin
                    pop = 1'b1;
                    asm_data_n[idx*IN_W +: IN_W] = head.data;
                    if ((idx == IDX_W'(RATIO - 1)) || head.last) begin
                        asm_keep_n = keep_for(idx);
                        asm_last_n = head.last;
                        state_n    = HOLD;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (!out_valid || bus.m_tready) begin
                    out_data_n  = asm_data;
                    out_keep_n  = asm_keep;
                    out_last_n  = asm_last;
                    out_valid_n = 1'b1;
                    state_n     = IDLE;
                    idx_n       = '0;
                    asm_data_n  = '0;
                    start       = (occ != '0);
                end
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            pop        = 1'b1;
            asm_data_n = OUT_W'(head.data);
            if ((RATIO == 1) || head.last) begin
                asm_keep_n = keep_for('0);
                asm_last_n = head.last;
                state_n    = HOLD;
            end else begin
                idx_n   = IDX_W'(1);
                state_n = FILL;
            end
        end
    end

    // All control, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            rd_vld    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            state     <= IDLE;
            idx       <= '0;
            asm_data  <= '0;
            asm_keep  <= '0;
            asm_last  <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            armed     <= 1'b1;
            rd_vld    <= READ_LATENCY'({rd_vld, bus.fifo_rden});
            wr_ptr    <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
            occ       <= occ + OCC_W'(push) - OCC_W'(pop);
            state     <= state_n;
            idx       <= idx_n;
            asm_data  <= asm_data_n;
            asm_keep  <= asm_keep_n;
            asm_last  <= asm_last_n;
            out_data  <= out_data_n;
            out_keep  <= out_keep_n;
            out_last  <= out_last_n;
            out_valid <= out_valid_n;
        end
    end

    assign bus.m_tdata  = out_data;
    assign bus.m_tkeep  = out_keep;
    assign bus.m_tlast  = out_last;
    assign bus.m_tvalid = out_valid;

    // Credit accounting must make a push into a full buffer impossible.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (occ == OCC_W'(BUF_DEPTH))));

`ifdef GZIP_PACKER_STATS_EN
    logic [31:0] beats_q;
    logic [15:0] frames_q;

    // Accepted-beat and frame counters, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            frames_q <= '0;
        end else if (out_valid && bus.m_tready) begin
            beats_q <= beats_q + 32'd1;
            if (out_last) begin
                frames_q <= frames_q + 16'd1;
            end
        end
    end

    assign beat_count  = beats_q;
    assign frame_count = frames_q;
`else
    assign beat_count  = '0;
    assign frame_count = '0;
`endif
endmodule

// File: tb/tb_gzip_axis_packer.sv
// Self-checking bench: two packers (read latency 1 and 3) fed the same word
// streams from a latency-accurate FIFO model, compared against a beat list
// derived from the packing rules.
module tb_gzip_axis_packer;
    localparam int unsigned IN_W      = 32;
    localparam int unsigned RATIO     = 2;
    localparam int unsigned OUT_W     = IN_W * RATIO;
    localparam int unsigned KEEP_W    = OUT_W / 8;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int          NI        = 2;
    localparam int          BUDGET    = 3000;

    typedef struct packed {
        logic            last;
        logic [IN_W-1:0] data;
    } word_t;

    typedef struct packed {
        logic [OUT_W-1:0]  data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    rmode = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    word_t stream_q[$];
    beat_t exp_q[$];
    word_t src_q[NI][$];
    beat_t got_q[NI][$];
    int    rden_cnt[NI];
    int    underflow[NI];
    int    stall_bad[NI];

    logic        tvalid_mon[NI];
    logic        rden_mon[NI];
    beat_t       out_mon[NI];
    logic [31:0] bc_mon[NI];
    logic [15:0] fc_mon[NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        gzip_axis_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();
        logic [31:0] bc;
        logic [15:0] fc;
        logic        rd_req = 1'b0;
        logic        rdy = 1'b0;
        logic        prev_stall = 1'b0;
        beat_t       prev_beat = '0;
        word_t       pipe [LAT];

        gzip_axis_packer #(
            .IN_W(IN_W), .RATIO(RATIO), .READ_LATENCY(LAT), .BUF_DEPTH(BUF_DEPTH)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(bus), .beat_count(bc), .frame_count(fc)
        );

        assign bus.m_tready = rdy;
        assign tvalid_mon[g] = bus.m_tvalid;
        assign rden_mon[g]   = bus.fifo_rden;
        assign out_mon[g]    = {bus.m_tdata, bus.m_tkeep, bus.m_tlast};
        assign bc_mon[g]     = bc;
        assign fc_mon[g]     = fc;

        always @(negedge clk) rd_req = bus.fifo_rden;

        // Registered-read FIFO: word appears LAT cycles after the read; junk otherwise.
        always begin
            word_t w;
            @(posedge clk);
            #1;
            w = {1'($urandom_range(0, 1)), 32'($urandom())};
            if (rd_req) begin
                rden_cnt[g]++;
                if (src_q[g].size() == 0) underflow[g]++;
                else w = src_q[g].pop_front();
            end
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = w;
            bus.fifo_data  = pipe[LAT-1].data;
            bus.fifo_last  = pipe[LAT-1].last;
            bus.fifo_empty = (src_q[g].size() == 0);
        end

        // Sink ready pattern.
        always begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'b0;
                2:       rdy = ~rdy;
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
        end

        // Collect accepted beats and watch output stability across stalls.
        always @(negedge clk) begin
            beat_t cur;
            cur = {bus.m_tdata, bus.m_tkeep, bus.m_tlast};
            if (rst_n) begin
                if (prev_stall && (!bus.m_tvalid || cur != prev_beat)) stall_bad[g]++;
                if (bus.m_tvalid && bus.m_tready) got_q[g].push_back(cur);
                prev_stall = bus.m_tvalid && !bus.m_tready;
            end else begin
                prev_stall = 1'b0;
            end
            prev_beat = cur;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [IN_W-1:0] d, input logic l);
        word_t w;
        w = '{last: l, data: d};
        stream_q.push_back(w);
        for (int k = 0; k < NI; k++) src_q[k].push_back(w);
    endtask

    // Reference: consecutive words group into beats of RATIO, cut early by last.
    function automatic void build_exp();
        beat_t b;
        int    n;
        exp_q.delete();
        b = '0;
        n = 0;
        foreach (stream_q[i]) begin
            b.data[n*IN_W +: IN_W] = stream_q[i].data;
            n++;
            if (stream_q[i].last || n == int'(RATIO)) begin
                b.keep = KEEP_W'((64'd1 << (n * int'(IN_W) / 8)) - 64'd1);
                b.last = stream_q[i].last;
                exp_q.push_back(b);
                b = '0;
                n = 0;
            end
        end
    endfunction

    task automatic wait_beats(input string tag, input int n);
        int cyc;
        cyc = 0;
        while ((got_q[0].size() < n || got_q[1].size() < n) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_in_time"}, 64'(cyc < BUDGET), 64'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_u%0d_count", tag, k), 64'(got_q[k].size()), 64'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q[k].size(); i++) begin
                check($sformatf("%s_u%0d_b%0d_data", tag, k, i), 64'(got_q[k][i].data), 64'(exp_q[i].data));
                check($sformatf("%s_u%0d_b%0d_keep", tag, k, i), 64'(got_q[k][i].keep), 64'(exp_q[i].keep));
                check($sformatf("%s_u%0d_b%0d_last", tag, k, i), 64'(got_q[k][i].last), 64'(exp_q[i].last));
            end
            got_q[k].delete();
        end
        stream_q.delete();
    endtask

    task automatic reset_checks(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_u%0d_tvalid", tag, k), 64'(tvalid_mon[k]), 64'd0);
            check($sformatf("%s_u%0d_beat", tag, k), 64'(out_mon[k]), 64'd0);
            check($sformatf("%s_u%0d_rden", tag, k), 64'(rden_mon[k]), 64'd0);
            check($sformatf("%s_u%0d_bcnt", tag, k), 64'(bc_mon[k]), 64'd0);
            check($sformatf("%s_u%0d_fcnt", tag, k), 64'(fc_mon[k]), 64'd0);
        end
    endtask

    // Roughly one-cycle reset pulse; source queues and pending results are dropped.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks(tag);
        @(posedge clk);
        #2;
        for (int k = 0; k < NI; k++) begin
            src_q[k].delete();
            got_q[k].delete();
        end
        stream_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        int n_last;
        for (int k = 0; k < NI; k++) begin
            rden_cnt[k] = 0; underflow[k] = 0; stall_bad[k] = 0;
        end

        // Reset state with data already waiting in the FIFO.
        rmode = 0;
        push_word(32'h11111111, 1'b0);
        push_word(32'h22222222, 1'b0);
        push_word(32'h33333333, 1'b0);
        push_word(32'h44444444, 1'b1);
        repeat (3) @(negedge clk);
        reset_checks("reset");
        #2;
        rst_n = 1'b1;

        // Two full beats.
        build_exp();
        wait_beats("t1", exp_q.size());
        for (int k = 0; k < NI; k++) begin
            check($sformatf("t1_u%0d_b1_const", k), 64'(got_q[k][1].data), 64'h4444444433333333);
        end
        compare_stream("t1");

        // Short final beat.
        push_word(32'h11111111, 1'b0);
        push_word(32'h22222222, 1'b0);
        push_word(32'h33333333, 1'b1);
        build_exp();
        wait_beats("t2", exp_q.size());
        for (int k = 0; k < NI; k++) begin
            check($sformatf("t2_u%0d_b1_const", k), 64'(got_q[k][1].data), 64'h0000000033333333);
            check($sformatf("t2_u%0d_b1_keep", k), 64'(got_q[k][1].keep), 64'h0f);
        end
        compare_stream("t2");

        // Long stall: credit must stop reads once every slot is full.
        rmode = 1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) rden_cnt[k] = 0;
        for (int i = 0; i < 10; i++) push_word(32'($urandom()), 1'(i == 9));
        repeat (30) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("t3_u%0d_rden_pulses", k), 64'(rden_cnt[k]), 64'd8);
            check($sformatf("t3_u%0d_no_beats", k), 64'(got_q[k].size()), 64'd0);
        end
        rmode = 0;
        build_exp();
        wait_beats("t3", exp_q.size());
        compare_stream("t3");

        // Alternating backpressure.
        rmode = 2;
        for (int i = 0; i < 16; i++) push_word(32'($urandom()), 1'(i == 15));
        build_exp();
        wait_beats("t4", exp_q.size());
        compare_stream("t4");
        rmode = 0;

        // Reset while reads are in flight; stale returns must be ignored.
        for (int i = 0; i < 40; i++) push_word(32'h50000000 + 32'(i), 1'(i == 39));
        cyc = 0;
        while (!tvalid_mon[1] && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_tvalid_seen", 64'(cyc < BUDGET), 64'd1);
        do_reset("t5_rst");
        for (int i = 0; i < 6; i++) push_word(32'ha0000000 + 32'(i), 1'(i == 5));
        build_exp();
        wait_beats("t5", exp_q.size());
        for (int k = 0; k < NI; k++) begin
            check($sformatf("t5_u%0d_first", k), 64'(got_q[k][0].data), 64'ha0000001a0000000);
        end
        compare_stream("t5");

        // Counters after two 5-word frames.
        do_reset("t6_rst");
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 5; i++) push_word(32'($urandom()), 1'(i == 4));
        end
        build_exp();
        n_last = 0;
        foreach (exp_q[i]) if (exp_q[i].last) n_last++;
        wait_beats("t6", exp_q.size());
        for (int k = 0; k < NI; k++) begin
`ifdef GZIP_PACKER_STATS_EN
            check($sformatf("t6_u%0d_beat_count", k), 64'(bc_mon[k]), 64'(exp_q.size()));
            check($sformatf("t6_u%0d_frame_count", k), 64'(fc_mon[k]), 64'(n_last));
`else
            check($sformatf("t6_u%0d_beat_count", k), 64'(bc_mon[k]), 64'd0);
            check($sformatf("t6_u%0d_frame_count", k), 64'(fc_mon[k]), 64'd0);
`endif
        end
        compare_stream("t6");

        // Random frames under random backpressure.
        rmode = 3;
        for (int s = 0; s < 30; s++) begin
            int len;
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) push_word(32'($urandom()), 1'(i == len - 1));
        end
        build_exp();
        wait_beats("t7", exp_q.size());
        compare_stream("t7");
        rmode = 0;

        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d_stall_stable", k), 64'(stall_bad[k]), 64'd0);
            check($sformatf("u%0d_underflow", k), 64'(underflow[k]), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
